non_max_suppression: RTL and testbench

- Canny stage directly downstream of gradient_calculation.
- Consumes the raster stream of gradient magnitude plus quantized direction, one pixel per valid cycle.
- Buffers two rows internally to form a 3x3 magnitude window, then thins edges: keeps the centre magnitude only if it is a local maximum along its gradient direction, otherwise outputs 0.
- Output feeds the double-threshold/hysteresis stage.

---
 rtl/canny_pkg.sv | 24 ++
 rtl/nms_line_buffer.sv | 26 ++
 rtl/non_max_suppression.sv | 173 +++++++++++++++++
 tb/tb_non_max_suppression.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny non-maximum suppression stage.
package canny_pkg;

  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;
  localparam int DEF_MAG_W = 11;

  typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;

  typedef enum logic {FILL, STREAM} nms_state_t;

  typedef struct packed {
    logic [DEF_MAG_W-1:0] mag;
    dir_t                 dir;
  } grad_px_t;

  // Asymmetric tie: strictly above the lead side, at least equal to the trail side.
  function automatic logic nms_keep(input logic [DEF_MAG_W-1:0] centre,
                                    input logic [DEF_MAG_W-1:0] lead,
                                    input logic [DEF_MAG_W-1:0] trail);
    return (centre > lead) && (centre >= trail);
  endfunction

endpackage

// File: rtl/nms_line_buffer.sv
// One image row of {mag,dir}, addressed by column; the read returns the old
// entry in the same cycle the new one is written.
module nms_line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  grad_px_t      wr_data,
  output grad_px_t      rd_data
);

  grad_px_t mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/non_max_suppression.sv
// Edge thinning: 3x3 magnitude window from two line buffers, keep centre only
// if it is a local maximum along its quantized gradient direction.
//
//   state  | meaning
//   FILL   | rows 0..1 of the frame; buffers load, nothing is emitted
//   STREAM | rows 2..H-1; each input at col>=2 emits centre (row-1, col-1)
module non_max_suppression
  import canny_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int MAG_W = DEF_MAG_W,  // must not exceed DEF_MAG_W
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] mag_in,
  input  logic [1:0]       dir_in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] nms_pixel_out,
  output logic             nms_out_valid,
  output logic             frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [DEF_MAG_W-1:0] SAT_MAX = DEF_MAG_W'((1 << OUT_W) - 1);

  nms_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Last two accepted columns of the window: [row r-2, r-1, r][col c-1, c].
  logic [2:0][1:0][DEF_MAG_W-1:0] mag_q, mag_d;
  dir_t cdir_q, cdir_d;

  logic [OUT_W-1:0] pix_q, pix_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  grad_px_t cur_px, lb0_rd, lb1_rd;
  logic col_last, row_last;
  logic [DEF_MAG_W-1:0] ctr_mag, lead_mag, trail_mag;
  logic unused_lb1_dir;

  assign cur_px.mag = DEF_MAG_W'(mag_in);
  assign cur_px.dir = dir_t'(dir_in);
  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);

  // The row two above is only needed for its magnitude.
  assign unused_lb1_dir = ^lb1_rd.dir;

  nms_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb_prev1 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (col_q),
    .wr_data (cur_px),
    .rd_data (lb0_rd)
  );

  nms_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb_prev2 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (col_q),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Window of the incoming pixel: W/N/NW etc. come from stored columns, the
  // east column is the current line-buffer read plus the live input.
  always_comb begin
    ctr_mag   = mag_q[1][1];
    lead_mag  = mag_q[1][0];
    trail_mag = lb0_rd.mag;
    unique case (cdir_q)
      DIR_0: begin
        lead_mag  = mag_q[1][0];
        trail_mag = lb0_rd.mag;
      end
      DIR_45: begin
        lead_mag  = lb1_rd.mag;
        trail_mag = mag_q[2][0];
      end
      DIR_90: begin
        lead_mag  = mag_q[0][1];
        trail_mag = mag_q[2][1];
      end
      DIR_135: begin
        lead_mag  = mag_q[0][0];
        trail_mag = cur_px.mag;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mag_d   = mag_q;
    cdir_d  = cdir_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        mag_d[r][0] = mag_q[r][1];
      end
      mag_d[0][1] = lb1_rd.mag;
      mag_d[1][1] = lb0_rd.mag;
      mag_d[2][1] = cur_px.mag;
      cdir_d      = lb0_rd.dir;

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      unique case (state_q)
        FILL:   if (col_last && row_q == ROW_ONE) state_d = STREAM;
        STREAM: if (col_last && row_last)         state_d = FILL;
        default: state_d = FILL;
      endcase

      if (state_q == STREAM && col_q >= COL_TWO) begin
        valid_d = 1'b1;
        done_d  = col_last && row_last;
        if (nms_keep(ctr_mag, lead_mag, trail_mag)) begin
          pix_d = (ctr_mag > SAT_MAX) ? {OUT_W{1'b1}} : ctr_mag[OUT_W-1:0];
        end else begin
          pix_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Window contents are qualified by the counters, so they need no reset.
  always_ff @(posedge clk) begin
    mag_q  <= mag_d;
    cdir_q <= cdir_d;
  end

  assign nms_pixel_out = pix_q;
  assign nms_out_valid = valid_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_non_max_suppression.sv
// Directed 5x5 frames against hand-computed thinned outputs.
module tb_non_max_suppression;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int MW = 11;
  localparam int OW = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] mag_in = '0;
  logic [1:0]    dir_in = '0;
  logic          in_valid = 1'b0;
  logic [OW-1:0] nms_pixel_out;
  logic          nms_out_valid;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_err = 0;
  int stray_done = 0;
  int out_q[$];
  int done_q[$];
  logic iv_at_edge;

  always #5 clk = ~clk;

  non_max_suppression #(.IMG_W(W), .IMG_H(H), .MAG_W(MW), .OUT_W(OW)) dut (
    .clk           (clk),
    .rst           (rst),
    .mag_in        (mag_in),
    .dir_in        (dir_in),
    .in_valid      (in_valid),
    .nms_pixel_out (nms_pixel_out),
    .nms_out_valid (nms_out_valid),
    .frame_done    (frame_done)
  );

  always @(posedge clk) begin
    iv_at_edge = in_valid & ~rst;
    #1;
    if (nms_out_valid) begin
      if (!iv_at_edge) stall_err++;
      out_q.push_back(int'(nms_pixel_out));
      done_q.push_back(int'(frame_done));
    end else if (frame_done) begin
      stray_done++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int row_val(input int r);
    if (r == 1) return 10;
    if (r == 2 || r == 3) return 20;
    return 0;
  endfunction

  function automatic int img_mag(input int id, input int r, input int c);
    case (id)
      0: return c * 10;
      1: return (r == 2 && c == 2) ? 300 : 0;
      2: return (c == 0 || c == 4) ? 0 : 50;
      3: return row_val(r);
      4: return (r == 2 && (c == 1 || c == 3)) ? 30 : row_val(r);
      default: return 0;
    endcase
  endfunction

  function automatic int img_dir(input int id);
    return (id == 3) ? 2 : 0;
  endfunction

  task automatic send_frame(input int id, input bit stall, input int first, input int last);
    for (int k = first; k < last; k++) begin
      if (stall && (k % 3 == 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      mag_in   = MW'(img_mag(id, k / W, k % W));
      dir_in   = 2'(img_dir(id));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic flush();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp [NOUT]);
    chk({tag, "_count"}, out_q.size(), NOUT);
    for (int i = 0; i < NOUT; i++) begin
      if (i < out_q.size()) begin
        chk($sformatf("%s_px%0d", tag, i), out_q[i], exp[i]);
        chk($sformatf("%s_done%0d", tag, i), done_q[i], (i == NOUT - 1) ? 1 : 0);
      end
    end
    out_q.delete();
    done_q.delete();
  endtask

  int e_zero [NOUT];
  int e_peak [NOUT];
  int e_plat [NOUT];
  int e_vert [NOUT];
  int e_horz [NOUT];

  initial begin
    e_zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    e_peak = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
    e_plat = '{50, 0, 0, 50, 0, 0, 50, 0, 0};
    e_vert = '{0, 0, 0, 20, 20, 20, 0, 0, 0};
    e_horz = '{0, 0, 0, 30, 0, 30, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_px", int'(nms_pixel_out), 0);
    chk("reset_valid", int'(nms_out_valid), 0);
    chk("reset_done", int'(frame_done), 0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(0, 1'b0, 0, W * H); flush(); check_frame("ramp", e_zero);
    send_frame(1, 1'b0, 0, W * H); flush(); check_frame("peak", e_peak);
    send_frame(2, 1'b0, 0, W * H); flush(); check_frame("plateau", e_plat);
    send_frame(3, 1'b0, 0, W * H); flush(); check_frame("dir90", e_vert);
    send_frame(4, 1'b0, 0, W * H); flush(); check_frame("dir0_we30", e_horz);
    send_frame(1, 1'b1, 0, W * H); flush(); check_frame("peak_stall", e_peak);

    send_frame(1, 1'b0, 0, 3 * W + 2);
    flush();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_q.delete();
    done_q.delete();
    send_frame(1, 1'b0, 0, 2 * W);
    flush();
    chk("rst_fill_rows_silent", out_q.size(), 0);
    send_frame(1, 1'b0, 2 * W, W * H);
    flush();
    check_frame("peak_after_rst", e_peak);

    chk("valid_after_idle_input", stall_err, 0);
    chk("done_without_valid", stray_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
